// File: rtl/mem_access_seq.sv
// -----------------------------------------------------------------------------
// mem_access_seq
//
// Memory access sequencer for the Simple RISC Machine. It sits directly in
// front of the RAM controller. It accepts fetch, load and store requests from
// the CPU control path and issues them as mem_cmd / mem_addr / write_data. It
// waits out the RAM's one-cycle synchronous read and then captures read_data
// into the load-data register (rsp_data) and, for fetches, the instruction
// register. It also owns the program counter.
//
// Ports
//   clk, reset             rising-edge clock; asynchronous active-high reset
//   req_valid/req_ready    request handshake; a request is accepted only in IDLE
//   req_type               00 fetch, 01 load, 10 store, 11 reserved (error)
//   req_addr, req_wdata    load/store address and store data
//   pc_load, pc_next       PC overwrite (branch/jump), honoured only in IDLE
//   pc, ir                 program counter and instruction register
//   mem_cmd                00 MNONE, 01 MREAD, 10 MWRITE
//   mem_addr, write_data   address and store data presented to the controller
//   read_data              controller read data, valid during the 2nd MREAD cycle
//   rsp_valid, rsp_err     one-cycle completion pulse; err marks a reserved type
//   rsp_data               last data returned by a fetch or load
// -----------------------------------------------------------------------------
module mem_access_seq #(
    parameter int unsigned       ADDR_W   = 9,
    parameter int unsigned       DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [1:0]        req_type,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_next,
    output logic [ADDR_W-1:0] pc,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [DATA_W-1:0] ir
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        REQ_FETCH = 2'b00,
        REQ_LOAD  = 2'b01,
        REQ_STORE = 2'b10,
        REQ_RSVD  = 2'b11
    } req_type_e;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    state_e            state_q, state_d;
    req_type_e         type_q, type_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    // Next-state and output decode.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d    = state_q;
        type_d     = type_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        rsp_data_d = rsp_data_q;
        mem_cmd    = MNONE;
        rsp_valid  = 1'b0;
        rsp_err    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pc_load) begin
                    pc_d = pc_next;
                end
                if (req_valid) begin
                    type_d  = req_type_e'(req_type);
                    wdata_d = req_wdata;
                    // A fetch issued together with a branch must go to the
                    // branch target, not the stale PC.
                    if (req_type_e'(req_type) == REQ_FETCH) begin
                        addr_d = pc_load ? pc_next : pc_q;
                    end else begin
                        addr_d = req_addr;
                    end
                    unique case (req_type_e'(req_type))
                        REQ_FETCH, REQ_LOAD: state_d = RD_ADDR;
                        REQ_STORE:           state_d = WR;
                        default:             state_d = DONE;
                    endcase
                end
            end
            // The RAM read is synchronous: the first MREAD cycle presents the
            // address, the second one has read_data valid for capture.
            RD_ADDR: begin
                mem_cmd = MREAD;
                state_d = RD_DATA;
            end
            RD_DATA: begin
                mem_cmd    = MREAD;
                state_d    = DONE;
                rsp_data_d = read_data;
                if (type_q == REQ_FETCH) begin
                    ir_d = read_data;
                    pc_d = addr_q + ADDR_W'(1);
                end
            end
            WR: begin
                mem_cmd = MWRITE;
                state_d = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                rsp_err   = (type_q == REQ_RSVD);
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset drops the state to IDLE at once, so
    // mem_cmd (decoded from state) falls to MNONE without waiting for a clock
    // and an interrupted store never reaches the RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            type_q     <= REQ_FETCH;
            addr_q     <= '0;
            wdata_q    <= '0;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            rsp_data_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its _d value from before this clock edge.
            state_q    <= state_d;
            type_q     <= type_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign mem_addr   = addr_q;
    assign write_data = wdata_q;
    assign pc         = pc_q;
    assign ir         = ir_q;
    assign rsp_data   = rsp_data_q;

endmodule

// File: doc/mem_access_seq.md
# mem_access_seq

Memory access sequencer for the Simple RISC Machine. It sits directly upstream of the RAM controller. It accepts instruction-fetch, load and store requests from the CPU control path, then drives `mem_cmd`, `mem_addr` and `write_data` into the controller. It accounts for the RAM's one-cycle synchronous read and captures `read_data` into the instruction register or the load-data register. It also owns the program counter.

## Interface
- `ADDR_W`, 9: memory address width; bit 8 set selects non-RAM (I/O) space.
- `DATA_W`, 16: data word width.
- `RESET_PC`, 9'h000: PC value loaded on reset.

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_type`  in  2  00 fetch, 01 load, 10 store, 11 reserved.
- `req_addr`  in  ADDR_W  load/store address; ignored for fetch.
- `req_wdata`  in  DATA_W  store data.
- `req_ready`  out  1  sequencer can accept a request this cycle.
- `pc_load`  in  1  overwrite PC with `pc_next` (branch/jump).
- `pc_next`  in  ADDR_W  new PC value.
- `pc`  out  ADDR_W  current program counter.
- `mem_cmd`  out  2  00 MNONE, 01 MREAD, 10 MWRITE.
- `mem_addr`  out  ADDR_W  address to RAM controller.
- `write_data`  out  DATA_W  store data to RAM controller.
- `read_data`  in  DATA_W  data from RAM controller; valid only while MREAD has been held for a full cycle.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_data`  out  DATA_W  captured load/fetch data.
- `rsp_err`  out  1  qualifies `rsp_valid`: reserved `req_type`.
- `ir`  out  DATA_W  instruction register.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR, DONE.
- Accept rule: a request is accepted on a rising edge where `req_ready & req_valid`. `req_ready = (state==IDLE)`.
- On accept, register type, address and wdata internally.
  - Fetch uses `pc`. If `pc_load` is high in the same cycle, fetch uses `pc_next` instead.
- Transitions on accept:
  - fetch/load: IDLE→RD_ADDR→RD_DATA→DONE→IDLE.
  - store: IDLE→WR→DONE→IDLE.
  - reserved: IDLE→DONE→IDLE. No memory command issued; `rsp_err=1` in DONE.
- `mem_cmd` decode: MREAD in RD_ADDR and RD_DATA; MWRITE in WR; MNONE in IDLE and DONE.
- `mem_addr` and `write_data` come from the latched request registers and are stable for every cycle a command is asserted. They hold their last value otherwise.
- Capture at the edge ending RD_DATA:
  - `rsp_data <= read_data` (fetch and load).
  - Fetch only: `ir <= read_data` and `pc <= captured address + 1`, modulo 2^ADDR_W (511→0).
- PC updates:
  - `pc_load` is honoured only in IDLE. It is ignored while busy; the issuer must hold it.
  - Loads, stores and reserved requests never change `pc`.
- `rsp_data` is unchanged by stores and reserved requests.
- I/O addresses (bit 8 set) are issued exactly like RAM addresses; decode is downstream.

## Timing
- Reset values: state IDLE; `pc=RESET_PC`; `ir=0`; `rsp_data=0`; `rsp_valid=0`; `rsp_err=0`; `mem_cmd=MNONE`; `mem_addr=0`; `write_data=0`; `req_ready=1`. Requests are ignored while `reset` is high.
- Read latency, with the accept at the edge ending cycle N:
  - cycles N+1 and N+2: MREAD.
  - edge ending N+2: data captured.
  - cycle N+3: `rsp_valid=1`.
  - cycle N+4: earliest next accept (back-to-back throughput is one read per 4 cycles).
- Store latency, with the accept at the edge ending cycle N:
  - cycle N+1: MWRITE; RAM writes at the edge ending N+1.
  - cycle N+2: `rsp_valid=1`.
- `rsp_valid` is high exactly one cycle, in DONE. `rsp_data` holds until the next capture.
- Reset mid-operation:
  - Immediately (asynchronously) `mem_cmd=MNONE` and state IDLE.
  - No `rsp_valid`; `pc` and `ir` return to reset values.
  - A store commits only if `reset` is low at the edge ending WR.

## Test plan
- Reset, then fetch with RAM[0]=16'hD105 → MREAD with `mem_addr=0` for exactly 2 cycles; `ir=rsp_data=16'hD105`; `pc=1`; `rsp_valid` one pulse at cycle N+3.
- Store addr 9'h042 data 16'hBEEF, then load 9'h042 → one MWRITE cycle, `rsp_valid` at N+2; the load returns 16'hBEEF; `pc` unchanged.
- `pc_load=1`, `pc_next=9'h1FF` with a simultaneous fetch → fetch reads addr 9'h1FF; `pc` afterwards is 9'h000 (wrap).
- `req_valid` held high with alternating load/fetch → accepts only in IDLE, every 4 cycles; `req_ready` low in all busy states; `pc_load` pulsed while busy has no effect.
- Reserved `req_type=11` → no cycle with `mem_cmd≠MNONE`; `rsp_valid=rsp_err=1` the next cycle; `rsp_data` unchanged.
- `reset` asserted mid-RD_DATA and mid-WR → `mem_cmd` goes to MNONE before the next edge; no `rsp_valid`; the aborted store leaves RAM contents unchanged.
